// File: rtl/gsensor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gsensor_pkg
//  Brief    : Shared types and constants for the G-sensor boxcar filter.
//             Covers the FSM state encoding, the helpers that derive the
//             window depth and the sum width, and the 10-bit LED clamp range.
//  Revision : 1.0 - initial release
// ============================================================================
package gsensor_pkg;

  // Filter sequencing: one sample walks IDLE -> READ -> UPD -> OUT
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    UPD  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // led_driver consumes bits [9:0], so the clamp range is 10-bit signed
  localparam int SAT_MAX = 511;
  localparam int SAT_MIN = -512;

  // Window depth for a given log2 size
  function automatic int calc_depth(input int log2_depth);
    return 1 << log2_depth;
  endfunction

  // Running-sum width; DEPTH samples of DATA_W bits cannot overflow it
  function automatic int calc_sum_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gsensor_avg_ram.sv
`default_nettype none
// ============================================================================
//  Module   : gsensor_avg_ram
//  Brief    : Ring-buffer storage for the moving-average window.
//             Register file with a registered read port and a synchronous
//             write port. Contents are deliberately not reset: the filter
//             masks stale entries until the window has filled.
//  Revision : 1.0 - initial release
// ============================================================================
module gsensor_avg_ram
  import gsensor_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Synchronous write of the newest sample
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read of the entry about to be evicted
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/gsensor_avg_filter.sv
`default_nettype none
// ============================================================================
//  Module   : gsensor_avg_filter
//  Brief    : Boxcar moving-average filter for one accelerometer axis.
//             Keeps the last 2^LOG2_DEPTH samples in a ring buffer with a
//             running sum and emits the floor mean with a one-cycle valid.
//             Optional macro GSENSOR_AVG_SAT_EN clamps the output to the
//             10-bit signed range used by led_driver.
//  Revision : 1.0 - initial release
// ============================================================================
module gsensor_avg_filter
  import gsensor_pkg::*;
#(
  parameter int LOG2_DEPTH = 3,
  parameter int DATA_W     = 16
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iCLR,
  input  logic                     iSTB,
  input  logic signed [DATA_W-1:0] iDATA,
  output logic signed [DATA_W-1:0] oDATA,
  output logic                     oVALID,
  output logic                     oBUSY,
  output logic                     oFULL,
  output logic                     oOVERRUN
);

  localparam int DEPTH = calc_depth(LOG2_DEPTH);
  localparam int SUM_W = calc_sum_w(DATA_W, LOG2_DEPTH);
  localparam logic [LOG2_DEPTH:0] c_depth_cnt = (LOG2_DEPTH+1)'(DEPTH);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_W-1:0]       r_new;
  logic [SUM_W-1:0]        r_sum;
  logic [LOG2_DEPTH:0]     r_count;
  logic [LOG2_DEPTH-1:0]   r_wr_ptr;
  logic signed [DATA_W-1:0] r_data;
  logic                    r_valid;
  logic                    r_overrun;

  logic [DATA_W-1:0]       w_rd_data;
  logic [DATA_W-1:0]       w_oldest;
  logic [SUM_W-1:0]        w_new_ext;
  logic [SUM_W-1:0]        w_old_ext;
  logic signed [DATA_W-1:0] w_mean;
  logic signed [DATA_W-1:0] w_out;
  logic                    w_full;
  logic                    w_accept;
  logic                    w_wr_en;

  assign w_full   = (r_count == c_depth_cnt);
  assign w_accept = (r_state == IDLE) && iSTB && !iCLR;
  assign w_wr_en  = (r_state == UPD) && !iCLR;

  // During warm-up the slot being replaced holds nothing meaningful
  assign w_oldest  = w_full ? w_rd_data : '0;
  assign w_new_ext = {{LOG2_DEPTH{r_new[DATA_W-1]}}, r_new};
  assign w_old_ext = {{LOG2_DEPTH{w_oldest[DATA_W-1]}}, w_oldest};

  // Dropping the low bits of the sum is an arithmetic shift (floor divide)
  assign w_mean = r_sum[SUM_W-1:LOG2_DEPTH];

`ifdef GSENSOR_AVG_SAT_EN
  localparam logic signed [DATA_W-1:0] c_sat_max = DATA_W'(SAT_MAX);
  localparam logic signed [DATA_W-1:0] c_sat_min = DATA_W'(SAT_MIN);

  // Clamp the mean into the range the LED stage can display
  always_comb begin
    w_out = w_mean;
    if (w_mean > c_sat_max) begin
      w_out = c_sat_max;
    end else if (w_mean < c_sat_min) begin
      w_out = c_sat_min;
    end
  end
`else
  assign w_out = w_mean;
`endif

  gsensor_avg_ram #(
    .ADDR_W (LOG2_DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk     (iCLK),
    .i_rd_en   (r_state == READ),
    .i_rd_addr (r_wr_ptr),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (r_new)
  );

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: fixed walk through the pipeline, clear always returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (iSTB) w_state_nxt = READ;
      READ:    w_state_nxt = UPD;
      UPD:     w_state_nxt = OUT;
      OUT:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (iCLR) begin
      w_state_nxt = IDLE;
    end
  end

  // Datapath: sample latch, running sum, ring pointer, fill count and outputs
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_new     <= '0;
      r_sum     <= '0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (iCLR) begin
        // oDATA intentionally holds its last value across a clear
        r_sum     <= '0;
        r_count   <= '0;
        r_wr_ptr  <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_accept) begin
          r_new <= iDATA;
        end
        if (iSTB && (r_state != IDLE)) begin
          r_overrun <= 1'b1;
        end
        if (r_state == UPD) begin
          r_sum    <= r_sum + w_new_ext - w_old_ext;
          r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
          if (!w_full) begin
            r_count <= r_count + (LOG2_DEPTH+1)'(1);
          end
        end
        if (r_state == OUT) begin
          r_data  <= w_out;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign oDATA    = r_data;
  assign oVALID   = r_valid;
  assign oBUSY    = (r_state != IDLE);
  assign oFULL    = w_full;
  assign oOVERRUN = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_gsensor_avg_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gsensor_avg_filter
//  Brief    : Directed self-checking bench for gsensor_avg_filter
//             (LOG2_DEPTH=3, DATA_W=16). Honours GSENSOR_AVG_SAT_EN when
//             computing the expected saturation result.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gsensor_avg_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        stb;
  logic [15:0] din;
  logic [15:0] dout;
  logic        valid;
  logic        busy;
  logic        full;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;

  gsensor_avg_filter #(
    .LOG2_DEPTH (3),
    .DATA_W     (16)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iCLR     (clr),
    .iSTB     (stb),
    .iDATA    (din),
    .oDATA    (dout),
    .oVALID   (valid),
    .oBUSY    (busy),
    .oFULL    (full),
    .oOVERRUN (overrun)
  );

  always #5 clk = ~clk;

  // Count valid pulses away from the active edge
  always @(negedge clk) begin
    if (valid) n_valid++;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobe, bounded wait for oVALID, check the mean, then idle out the spacing
  task automatic send_sample(input logic [15:0] d, input string tag, input logic [15:0] exp);
    bit seen;
    @(posedge clk); #1;
    stb = 1'b1;
    din = d;
    @(posedge clk); #1;
    stb = 1'b0;
    din = '0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    check_value({tag, "_vld"}, 32'(seen), 32'd1);
    if (seen) check_value(tag, 32'(dout), 32'(exp));
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_sat;
    rst = 1'b1;
    clr = 1'b0;
    stb = 1'b0;
    din = '0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_data", 32'(dout), 32'h0);
    check_value("rst_flags", {28'h0, valid, busy, full, overrun}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Fill ramp: the n-th mean is 8*n, full only on the 8th
    for (int n = 1; n <= 8; n++) begin
      send_sample(16'h0040, $sformatf("fill%0d", n), 16'(8 * n));
      if (n == 7) check_value("full_at7", 32'(full), 32'd0);
    end
    check_value("full_at8", 32'(full), 32'd1);

    // Wrap and sign: mean steps 64 -> -64 in 16s
    for (int k = 1; k <= 8; k++) begin
      send_sample(16'hFFC0, $sformatf("wrap%0d", k), 16'(64 - 16 * k));
    end
    check_value("full_wrap", 32'(full), 32'd1);
    check_value("ovr_clean", 32'(overrun), 32'd0);

    // Latency and overrun: strobe sampled at E0, another at E2, another at E4
    base = n_valid;
    @(posedge clk); #1;
    stb = 1'b1; din = 16'h0040;
    @(posedge clk); #1;               // after E0
    stb = 1'b0;
    @(posedge clk); #1;               // after E1
    stb = 1'b1; din = 16'h7FFF;
    @(posedge clk); #1;               // after E2
    stb = 1'b0;
    check_value("ovr_set", 32'(overrun), 32'd1);
    check_value("lat_e2_vld", 32'(valid), 32'd0);
    @(posedge clk); #1;               // after E3
    check_value("lat_e3_vld", 32'(valid), 32'd1);
    check_value("lat_e3_data", 32'(dout), 32'h0000FFD0);
    stb = 1'b1; din = 16'h0040;
    @(posedge clk); #1;               // after E4
    stb = 1'b0;
    check_value("lat_e4_vld", 32'(valid), 32'd0);
    check_value("e4_accept_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;                               // after E7
    check_value("e4_vld", 32'(valid), 32'd1);
    check_value("e4_data", 32'(dout), 32'h0000FFE0);
    @(negedge clk); #1;
    check_value("vld_count", 32'(n_valid - base), 32'd2);
    repeat (4) @(posedge clk);

    // Clear one edge after an accepted strobe
    base = n_valid;
    @(posedge clk); #1;
    stb = 1'b1; din = 16'h1234;
    @(posedge clk); #1;               // after E0
    stb = 1'b0; clr = 1'b1;
    @(posedge clk); #1;               // after E1
    clr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_value("clr_no_vld", 32'(n_valid - base), 32'd0);
    check_value("clr_flags", {29'h0, busy, full, overrun}, 32'h0);
    check_value("clr_hold", 32'(dout), 32'h0000FFE0);
    send_sample(16'h0008, "clr_next", 16'h0001);

    // Clear and strobe together: clear wins, no overrun
    @(posedge clk); #1;
    stb = 1'b1; clr = 1'b1; din = 16'h5555;
    @(posedge clk); #1;
    stb = 1'b0; clr = 1'b0;
    check_value("clr_stb_busy", 32'(busy), 32'd0);
    check_value("clr_stb_ovr", 32'(overrun), 32'd0);
    repeat (3) @(posedge clk);

    // Rounding toward minus infinity from an empty window
    send_sample(16'hFFFF, "round", 16'hFFFF);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    stb = 1'b1; din = 16'h0100;
    @(posedge clk); #1;               // after E0
    stb = 1'b0;
    @(posedge clk); #3;               // mid-cycle after E1
    rst = 1'b1;
    #1;
    check_value("arst_busy", 32'(busy), 32'd0);
    check_value("arst_data", 32'(dout), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Saturation: fill with 0x0400 from empty
    for (int n = 1; n <= 8; n++) begin
      exp_sat = 128 * n;
`ifdef GSENSOR_AVG_SAT_EN
      if (exp_sat > 511) exp_sat = 511;
`endif
      send_sample(16'h0400, $sformatf("sat%0d", n), 16'(exp_sat));
    end
    check_value("sat_full", 32'(full), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
